pe_psum_collector: RTL and testbench
====================================

// Module: pe_psum_collector
// PURPOSE
//  Output-side partner of the pe_fp16 array. It sits at the bottom of a PE column and captures psum_out.
//  pe_fp16 has no valid/stall signals, so this block tracks each issued token through a PE_LATENCY delay line.
//  It samples the column's psum at the matching cycle and buffers results in a FIFO with a valid/ready output.
//  It returns credit (issue_ready) to the feeder, so the non-stallable PE pipeline can never overflow the FIFO.
// PARAMETERS
//  PE_LATENCY  3   cycles from feeder issue (ifmap_in/psum_in driven at column top) to psum_out valid at the collector
//  FIFO_DEPTH  8   result buffer entries, power of two, >= PE_LATENCY+1
//  CNT_W       16  width of the job result counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  start        in   1      pulse: begin a job of num_results results (honoured only in IDLE)
//  num_results  in   CNT_W  results in the job, latched on start
//  issue_valid  in   1      feeder drives a valid ifmap/psum token into the column this cycle
//  issue_ready  out  1      feeder may issue this cycle (credit available)
//  pe_psum      in   16     FP16 psum_out of last PE in column
//  res_valid    out  1      res_data holds a result
//  res_ready    in   1      downstream accepts result
//  res_data     out  16     FP16 result
//  res_last     out  1      res_data is the final result of the job
//  res_flags    out  2      {is_nan, is_inf} of res_data
//  busy         out  1      state != IDLE
//  done         out  1      one-cycle pulse when last result popped
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; delay line cleared; counters 0; state IDLE.
//  Issue fires when issue_valid && issue_ready. If issue_valid is high while issue_ready is low, the token is ignored (not tracked).
//  Delay line: shift register of PE_LATENCY bits. Bit 0 is loaded with the fire flag.
//  When the top bit is 1, pe_psum is pushed into the FIFO in that same cycle.
//  inflight = popcount(delay line).
//  issue_ready = (state==RUN) && (issued < num_q) && (fifo_count + inflight < FIFO_DEPTH), all registered-state based.
//  Credit counts the current FIFO level: a pop this cycle does not add credit until the next cycle. This rule guarantees a push never hits a full FIFO.
//  Push and pop in the same cycle are legal at any occupancy. A full FIFO with push+pop keeps its count unchanged.
//  Output: res_valid = !fifo_empty. res_data and res_flags come from the FIFO head, first-word-fall-through.
//  Data and flags hold stable while res_valid && !res_ready.
//  res_last = res_valid && (popped == num_q-1).
//  Flags (combinational on head): exp==5'h1F && man!=0 -> nan; exp==5'h1F && man==0 -> inf.
//  -0.0 (8000) passes through unchanged with flags 00.
//  FSM:
//   IDLE : on start, latch num_q and clear issued/popped. If num_results==0 -> DONE, else -> RUN.
//   RUN  : when issued==num_q -> DRAIN.
//   DRAIN: when popped==num_q (last pop accepted) -> DONE.
//   DONE : done=1 for one cycle -> IDLE.
//  start outside IDLE is ignored. issue_valid outside RUN is ignored.
//  rst mid-job: in-flight tokens and FIFO contents are discarded. Any PE output arriving afterwards is not captured.
//  Counters never wrap: issued <= num_q and popped <= num_q.
// STRUCTURE
//  Shared defs file pe_fp16_defs.vh holds:
//   - FP16_W=16, FP16_EXP_MAX=5'h1F, exp/mantissa field ranges
//   - FSM state encodings S_IDLE/S_RUN/S_DRAIN/S_DONE
//   - the default PE_LATENCY shared with pe_fp16
//  One sub-module: pe_res_fifo (sync FWFT FIFO; params WIDTH, DEPTH; outputs count/full/empty).
//  The delay line, credit logic, flags and FSM live in pe_psum_collector.
// TESTING
//  Bench parameters: PE_LATENCY=3, FIFO_DEPTH=4. A PE model drives pe_psum with expected values at fire+3.
//  1. start num=4; issue 4 back-to-back with pe_psum 4000, 4400, 4700, 3E00 at t+3; res_ready=1
//     -> those 4 outputs in order; res_last only on 3E00; done pulses 1 cycle after that pop.
//  2. num=6; res_ready=0; feeder holds issue_valid=1
//     -> issue_ready drops after 4 issues; FIFO full with 4 entries; no loss.
//     Then raise res_ready -> remaining 2 issue; all 6 results arrive in order.
//  3. pe_psum 7C00, FE00, 8000
//     -> flags 01, 10, 00 respectively; data unchanged.
//  4. start with num_results=0 -> DONE the next cycle, done pulses, res_valid never asserts.
//     A second start while busy is ignored: num_q unchanged.
//  5. Assert rst in DRAIN with 2 entries buffered and 1 in flight
//     -> next cycle: res_valid=0, busy=0, issue_ready=0; the in-flight psum arriving later is not pushed.
//  6. res_ready toggling 1/0 every cycle with continuous issue
//     -> res_data stable while stalled; push+pop at full FIFO keeps order; total popped == num.

Source files
------------

// File: rtl/pe_psum_collector_pkg.sv
// rtl/pe_psum_collector_pkg.sv - shared FP16 field definitions, FSM states and flag helper
package pe_psum_collector_pkg;

    localparam int FP16_W             = 16;
    localparam logic [4:0] FP16_EXP_MAX = 5'h1F;
    localparam int FP16_EXP_MSB       = 14;
    localparam int FP16_EXP_LSB       = 10;
    localparam int FP16_MAN_MSB       = 9;
    localparam int FP16_MAN_LSB       = 0;

    // Must match the pipeline depth of pe_fp16 from issue to psum_out at the column bottom.
    localparam int PE_LATENCY_DEFAULT = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Returns {is_nan, is_inf}; -0.0 and all finite values give 2'b00.
    function automatic logic [1:0] fp16_flags(input logic [FP16_W-1:0] v);
        logic [FP16_EXP_MSB-FP16_EXP_LSB:0] e;
        logic [FP16_MAN_MSB-FP16_MAN_LSB:0] m;
        e = v[FP16_EXP_MSB:FP16_EXP_LSB];
        m = v[FP16_MAN_MSB:FP16_MAN_LSB];
        return {(e == FP16_EXP_MAX) && (|m), (e == FP16_EXP_MAX) && (~|m)};
    endfunction

endpackage

// File: rtl/pe_res_fifo.sv
// rtl/pe_res_fifo.sv - synchronous first-word-fall-through result FIFO
module pe_res_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/pe_psum_collector.sv
// rtl/pe_psum_collector.sv - captures column psum via an issue-tracking delay line and returns FIFO credit
module pe_psum_collector
    import pe_psum_collector_pkg::*;
#(
    parameter int PE_LATENCY = PE_LATENCY_DEFAULT,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_results,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [FP16_W-1:0] pe_psum,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [FP16_W-1:0] res_data,
    output logic              res_last,
    output logic [1:0]        res_flags,
    output logic              busy,
    output logic              done
);

    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + PE_LATENCY + 1) + 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      num_q, num_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [CNT_W-1:0]      popped_q, popped_d;
    logic [PE_LATENCY-1:0] delay_q, delay_d;

    logic              fire;
    logic              push;
    logic              pop;
    logic              credit_ok;
    logic [OCC_W-1:0]  inflight;
    logic [FC_W-1:0]   fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FP16_W-1:0] fifo_head;

    assign fire = issue_valid && issue_ready;
    assign push = delay_q[PE_LATENCY-1];
    assign pop  = res_valid && res_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < PE_LATENCY; i++) begin
            inflight = inflight + OCC_W'(delay_q[i]);
        end
    end

    // Credit uses only registered occupancy, so a same-cycle pop frees space one cycle later.
    assign credit_ok   = (OCC_W'(fifo_count) + inflight) < OCC_W'(FIFO_DEPTH);
    assign issue_ready = (state_q == S_RUN) && (issued_q < num_q) && credit_ok;

    always_comb begin
        delay_d    = delay_q << 1;
        delay_d[0] = fire;
    end

    pe_res_fifo #(
        .WIDTH (FP16_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pe_psum),
        .pop       (pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign res_valid = !fifo_empty;
    assign res_data  = fifo_empty ? '0 : fifo_head;
    assign res_flags = fifo_empty ? 2'b00 : fp16_flags(fifo_head);
    assign res_last  = res_valid && (popped_q == num_q - CNT_W'(1));
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        issued_d = issued_q;
        popped_d = popped_q;
        if (fire) issued_d = issued_q + CNT_W'(1);
        if (pop && (popped_q < num_q)) popped_d = popped_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d    = num_results;
                    issued_d = '0;
                    popped_d = '0;
                    state_d  = (num_results == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN:   if (issued_q == num_q) state_d = S_DRAIN;
            S_DRAIN: if (popped_d == num_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            num_q    <= '0;
            issued_q <= '0;
            popped_q <= '0;
            delay_q  <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            popped_q <= popped_d;
            delay_q  <= delay_d;
        end
    end

    // The credit scheme must never let a tracked psum meet a full FIFO without a matching pop.
    always_ff @(posedge clk) begin
        if (!rst && push && !pop) assert (!fifo_full);
    end

endmodule

// File: tb/tb_pe_psum_collector.sv
// tb/tb_pe_psum_collector.sv - randomized self-checking bench with a token-order reference model
module tb_pe_psum_collector;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_results;
    logic          issue_valid;
    logic          issue_ready;
    logic [15:0]   pe_psum;
    logic          res_valid;
    logic          res_ready;
    logic [15:0]   res_data;
    logic          res_last;
    logic [1:0]    res_flags;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    pe_psum_collector #(
        .PE_LATENCY (LAT),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_results (num_results),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .pe_psum     (pe_psum),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_last    (res_last),
        .res_flags   (res_flags),
        .busy        (busy),
        .done        (done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // PE column model: value due at the collector on a given clock edge (ring indexed by edge number).
    logic [15:0] sched_v  [8];
    bit          sched_ok [8];
    logic [15:0] plan_q [$];
    logic [15:0] exp_q  [$];
    int          fe_q   [$];

    function automatic logic [1:0] ref_flags(input logic [15:0] v);
        int vi, e, m;
        vi = int'(v);
        e  = (vi / 1024) % 32;
        m  = vi % 1024;
        return {(e == 31) && (m != 0), (e == 31) && (m == 0)};
    endfunction

    task automatic tick();
        logic [2:0] idx;
        @(posedge clk);
        #1;
        cyc++;
        idx = 3'((cyc + 1) % 8);
        if (sched_ok[idx]) begin
            pe_psum       = sched_v[idx];
            sched_ok[idx] = 1'b0;
        end else begin
            pe_psum = 16'($urandom);
        end
    endtask

    task automatic schedule_token(input logic [15:0] v);
        logic [2:0] idx;
        idx           = 3'((cyc + 1 + LAT) % 8);
        sched_v[idx]  = v;
        sched_ok[idx] = 1'b1;
    endtask

    // rmode: 0 ready always, 1 toggling, 2 held low until 'hold', 3 random
    task automatic run_job(input int num, input int rmode, input int hold, input int restart_at,
                           output int fired_at_hold);
        int fired, popped, done_cyc, c;
        bit got_done;
        logic exp_rdy, exp_val;
        logic [15:0] v;
        fired = 0; popped = 0; got_done = 0; fired_at_hold = -1;
        exp_q.delete();
        fe_q.delete();
        start = 1'b1; num_results = CW'(num); issue_valid = 1'b0; res_ready = 1'b0;
        tick();
        start = 1'b0;
        done_cyc = (num == 0) ? cyc : -10;
        for (c = 0; c < 400 && !got_done; c++) begin
            exp_rdy = (num > 0) && (fired < num) && ((fired - popped) < DEPTH);
            exp_val = (exp_q.size() > 0) && (fe_q[0] + LAT <= cyc);
            total++;
            if (issue_ready !== exp_rdy) begin
                bad++;
                $display("FAIL issue_ready num=%0d c=%0d got=%b exp=%b", num, c, issue_ready, exp_rdy);
            end
            total++;
            if (res_valid !== exp_val) begin
                bad++;
                $display("FAIL res_valid num=%0d c=%0d got=%b exp=%b", num, c, res_valid, exp_val);
            end
            if (exp_val && res_valid) begin
                total++;
                if (res_data !== exp_q[0]) begin
                    bad++;
                    $display("FAIL res_data num=%0d idx=%0d got=%h exp=%h", num, popped, res_data, exp_q[0]);
                end
                total++;
                if (res_flags !== ref_flags(exp_q[0])) begin
                    bad++;
                    $display("FAIL res_flags data=%h got=%b exp=%b", exp_q[0], res_flags, ref_flags(exp_q[0]));
                end
                total++;
                if (res_last !== (popped == num - 1)) begin
                    bad++;
                    $display("FAIL res_last num=%0d idx=%0d got=%b", num, popped, res_last);
                end
            end
            total++;
            if (done !== (cyc == done_cyc)) begin
                bad++;
                $display("FAIL done num=%0d c=%0d got=%b exp=%b", num, c, done, cyc == done_cyc);
            end
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_in_job num=%0d c=%0d got=%b exp=1", num, c, busy);
            end
            if (done === 1'b1) got_done = 1'b1;
            if (c == hold - 1) fired_at_hold = fired;

            issue_valid = 1'b1;
            case (rmode)
                0:       res_ready = 1'b1;
                1:       res_ready = c[0];
                2:       res_ready = (c >= hold);
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
            if (c == restart_at) begin
                start = 1'b1;
                num_results = CW'(num + 5);
            end else begin
                start = 1'b0;
            end
            if (issue_valid && issue_ready) begin
                v = (plan_q.size() > 0) ? plan_q.pop_front() : 16'($urandom);
                exp_q.push_back(v);
                fe_q.push_back(cyc + 1);
                schedule_token(v);
                fired++;
            end
            if (res_valid && res_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                void'(fe_q.pop_front());
                popped++;
                if (popped == num) done_cyc = cyc + 1;
            end
            if (!got_done) tick();
        end
        issue_valid = 1'b0; start = 1'b0; res_ready = 1'b0;
        total++;
        if (!got_done) begin
            bad++;
            $display("FAIL job_timeout num=%0d got=no_done exp=done", num);
        end
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL after_done busy=%b done=%b exp=0/0", busy, done);
        end
        plan_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_results = '0; issue_valid = 1'b0; res_ready = 1'b0; pe_psum = '0;
        repeat (3) tick();
        total++;
        if ({issue_ready, res_valid, res_last, busy, done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=00000", {issue_ready, res_valid, res_last, busy, done});
        end
        total++;
        if (res_data !== 16'h0 || res_flags !== 2'b00) begin
            bad++;
            $display("FAIL reset_data got=%h/%b exp=0000/00", res_data, res_flags);
        end
        rst = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (issue_ready !== 1'b0 || res_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_issue_ignored i=%0d got=%b%b exp=00", i, issue_ready, res_valid);
            end
        end
        issue_valid = 1'b0;
    endtask

    task automatic test_basic_order();
        int f;
        plan_q = '{16'h4000, 16'h4400, 16'h4700, 16'h3E00};
        run_job(4, 0, 0, -1, f);
    endtask

    task automatic test_credit_backpressure();
        int f;
        repeat (6) plan_q.push_back(16'($urandom));
        run_job(6, 2, 12, -1, f);
        total++;
        if (f !== DEPTH) begin
            bad++;
            $display("FAIL credit_limit got=%0d exp=%0d", f, DEPTH);
        end
    endtask

    task automatic test_flags();
        int f;
        plan_q = '{16'h7C00, 16'hFE00, 16'h8000, 16'hFC00, 16'h7BFF, 16'h7C01};
        run_job(6, 0, 0, -1, f);
    endtask

    task automatic test_zero_and_restart();
        int f;
        run_job(0, 0, 0, -1, f);
        run_job(3, 0, 0, 2, f);
    endtask

    task automatic test_reset_mid_job();
        start = 1'b1; num_results = CW'(3); issue_valid = 1'b0; res_ready = 1'b0;
        tick();
        start = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (issue_ready !== 1'b1) begin
                bad++;
                $display("FAIL mid_issue_ready i=%0d got=%b exp=1", i, issue_ready);
            end
            schedule_token(16'h5000 + 16'(i));
            tick();
        end
        issue_valid = 1'b0;
        repeat (2) tick();
        total++;
        if (res_valid !== 1'b1 || busy !== 1'b1 || res_data !== 16'h5000) begin
            bad++;
            $display("FAIL pre_reset got=%b%b/%h exp=11/5000", res_valid, busy, res_data);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || issue_ready !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL post_reset got=%b%b%b%b exp=0000", res_valid, busy, issue_ready, done);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL late_psum_captured i=%0d got=%b%b exp=00", i, res_valid, busy);
            end
        end
        exp_q.delete();
        fe_q.delete();
    endtask

    task automatic test_back_to_back();
        int f;
        run_job(12, 1, 0, -1, f);
        run_job(16, 3, 0, -1, f);
        for (int k = 0; k < 10; k++) plan_q.push_back((k % 3 == 0) ? 16'h7C00 : 16'($urandom));
        run_job(10, 3, 0, -1, f);
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_credit_backpressure();
        test_flags();
        test_zero_and_restart();
        test_reset_mid_job();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
